// File: rtl/cache_pkg.sv
// Shared FSM state type, policy encodings and width helper for the cache tag engine.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    UPDATE = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic FIFO = 1'b0;
  localparam logic LRU  = 1'b1;
  localparam logic WB   = 1'b0;
  localparam logic WT   = 1'b1;

  // Ceiling log2; returns 0 for a value of 1.
  function automatic int log2w(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/cache_way_select.sv
// Combinational way selection for one set: tag hit detection and replacement victim choice.
module cache_way_select
  import cache_pkg::*;
#(
  parameter int ASSOC = 8,
  parameter int TAG_W = 36,
  localparam int WAY_W = log2w(ASSOC)
) (
  input  logic [ASSOC-1:0]            way_valid,
  input  logic [ASSOC-1:0][TAG_W-1:0] way_tag,
  input  logic [ASSOC-1:0][WAY_W-1:0] way_age,
  input  logic [TAG_W-1:0]            req_tag,
  output logic                        hit,
  output logic [WAY_W-1:0]            hit_way,
  output logic [WAY_W-1:0]            victim_way
);

  logic             have_invalid;
  logic [WAY_W-1:0] first_invalid;
  logic [WAY_W-1:0] oldest_way;

  // Scanning from the top index down lets the lowest matching way win.
  always_comb begin
    hit           = 1'b0;
    hit_way       = '0;
    have_invalid  = 1'b0;
    first_invalid = '0;
    oldest_way    = '0;
    for (int w = ASSOC - 1; w >= 0; w--) begin
      if (way_valid[w] && (way_tag[w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!way_valid[w]) begin
        have_invalid  = 1'b1;
        first_invalid = WAY_W'(w);
      end
      if (way_valid[w] && (way_age[w] == WAY_W'(ASSOC - 1))) begin
        oldest_way = WAY_W'(w);
      end
    end
    victim_way = have_invalid ? first_invalid : oldest_way;
  end

endmodule

// File: rtl/cache_tag_engine.sv
// Set-associative tag/state engine with FIFO/LRU replacement and WB/WT write policy.
// Optional statistics counters are built when CACHE_STATS_EN is defined.
//   state  | meaning
//   IDLE   | ready, waiting for a request
//   LOOKUP | tag compare, hit and victim way captured
//   UPDATE | set contents written, response fields captured
//   RESP   | resp_valid pulse, statistics update
module cache_tag_engine
  import cache_pkg::*;
#(
  parameter int ADDR_W    = 48,
  parameter int BLOCKSIZE = 64,
  parameter int CACHESIZE = 32768,
  parameter int ASSOC     = 8,
  parameter int CNT_W     = 32,
  localparam int OFFSET_W = log2w(BLOCKSIZE),
  localparam int NUMSETS  = CACHESIZE / (BLOCKSIZE * ASSOC),
  localparam int INDEX_W  = log2w(NUMSETS),
  localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              replace_policy,
  input  logic              write_policy,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              resp_evict,
  output logic [TAG_W-1:0]  resp_evict_tag,
  output logic              resp_writeback,
  output logic [CNT_W-1:0]  read_count,
  output logic [CNT_W-1:0]  write_count,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  writeback_count
);

  localparam int WAY_W = log2w(ASSOC);

  state_t             state;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               write_q, repl_q, wpol_q;
  logic               hit_q;
  logic [WAY_W-1:0]   hit_way_q, victim_q;

  logic [NUMSETS-1:0][ASSOC-1:0]            valid_mem, dirty_mem;
  logic [NUMSETS-1:0][ASSOC-1:0][TAG_W-1:0] tag_mem;
  logic [NUMSETS-1:0][ASSOC-1:0][WAY_W-1:0] age_mem;

  logic [ASSOC-1:0]            set_valid, set_dirty, next_valid, next_dirty;
  logic [ASSOC-1:0][TAG_W-1:0] set_tag, next_tag;
  logic [ASSOC-1:0][WAY_W-1:0] set_age, next_age;

  logic             sel_hit;
  logic [WAY_W-1:0] sel_hit_way, sel_victim;
  logic             allocate, victim_live;
  logic             unused_offset;

  assign unused_offset = ^req_addr[OFFSET_W-1:0];
  assign req_ready     = (state == IDLE);
  assign resp_valid    = (state == RESP);

  assign set_valid = valid_mem[req_index];
  assign set_dirty = dirty_mem[req_index];
  assign set_tag   = tag_mem[req_index];
  assign set_age   = age_mem[req_index];

  assign allocate    = !write_q || (wpol_q == WB);
  assign victim_live = set_valid[victim_q];

  cache_way_select #(.ASSOC(ASSOC), .TAG_W(TAG_W)) u_way_select (
    .way_valid  (set_valid),
    .way_tag    (set_tag),
    .way_age    (set_age),
    .req_tag    (req_tag),
    .hit        (sel_hit),
    .hit_way    (sel_hit_way),
    .victim_way (sel_victim)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      req_index <= '0;
      req_tag   <= '0;
      write_q   <= 1'b0;
      repl_q    <= FIFO;
      wpol_q    <= WB;
      hit_q     <= 1'b0;
      hit_way_q <= '0;
      victim_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_index <= req_addr[OFFSET_W +: INDEX_W];
            req_tag   <= req_addr[ADDR_W-1 -: TAG_W];
            write_q   <= req_write;
            repl_q    <= replace_policy;
            wpol_q    <= write_policy;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit_q     <= sel_hit;
          hit_way_q <= sel_hit_way;
          victim_q  <= sel_victim;
          state     <= UPDATE;
        end
        UPDATE:  state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Ages form a recency order within the set; 0 is the most recent.
  always_comb begin
    next_valid = set_valid;
    next_dirty = set_dirty;
    next_tag   = set_tag;
    next_age   = set_age;
    if (hit_q) begin
      if (repl_q == LRU) begin
        for (int w = 0; w < ASSOC; w++) begin
          if (set_valid[w] && (set_age[w] < set_age[hit_way_q])) next_age[w] = set_age[w] + WAY_W'(1);
        end
        next_age[hit_way_q] = '0;
      end
      if (write_q && (wpol_q == WB)) next_dirty[hit_way_q] = 1'b1;
    end else if (allocate) begin
      for (int w = 0; w < ASSOC; w++) begin
        if (set_valid[w] && (WAY_W'(w) != victim_q)) next_age[w] = set_age[w] + WAY_W'(1);
      end
      next_valid[victim_q] = 1'b1;
      next_dirty[victim_q] = write_q && (wpol_q == WB);
      next_tag[victim_q]   = req_tag;
      next_age[victim_q]   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_mem <= '0;
      dirty_mem <= '0;
      tag_mem   <= '0;
      age_mem   <= '0;
    end else if (state == UPDATE) begin
      valid_mem[req_index] <= next_valid;
      dirty_mem[req_index] <= next_dirty;
      tag_mem[req_index]   <= next_tag;
      age_mem[req_index]   <= next_age;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_hit       <= 1'b0;
      resp_evict     <= 1'b0;
      resp_evict_tag <= '0;
      resp_writeback <= 1'b0;
    end else if (state == UPDATE) begin
      resp_hit       <= hit_q;
      resp_evict     <= !hit_q && allocate && victim_live;
      resp_evict_tag <= (!hit_q && allocate && victim_live) ? set_tag[victim_q] : '0;
      resp_writeback <= !hit_q && allocate && victim_live && set_dirty[victim_q];
    end
  end

`ifdef CACHE_STATS_EN
  logic [CNT_W-1:0] rd_cnt, wr_cnt, hit_cnt, miss_cnt, wb_cnt;
  logic             wb_event;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

  // Write-through traffic counts as a memory write on every write request.
  assign wb_event = resp_writeback || (write_q && (wpol_q == WT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else if (state == RESP) begin
      if (write_q) wr_cnt <= sat_inc(wr_cnt);
      else         rd_cnt <= sat_inc(rd_cnt);
      if (resp_hit) hit_cnt  <= sat_inc(hit_cnt);
      else          miss_cnt <= sat_inc(miss_cnt);
      if (wb_event) wb_cnt <= sat_inc(wb_cnt);
    end
  end

  assign read_count      = rd_cnt;
  assign write_count     = wr_cnt;
  assign hit_count       = hit_cnt;
  assign miss_count      = miss_cnt;
  assign writeback_count = wb_cnt;
`else
  assign read_count      = '0;
  assign write_count     = '0;
  assign hit_count       = '0;
  assign miss_count      = '0;
  assign writeback_count = '0;
`endif

endmodule

// File: tb/tb_cache_tag_engine.sv
// Self-checking bench for cache_tag_engine: directed vector table, reset abort, randomized model compare.
module tb_cache_tag_engine;

`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [47:0] req_addr = '0;
  logic        replace_policy = 1'b0;
  logic        write_policy = 1'b0;
  logic        resp_valid, resp_hit, resp_evict, resp_writeback;
  logic [35:0] resp_evict_tag;
  logic [31:0] read_count, write_count, hit_count, miss_count, writeback_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cache_tag_engine dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .replace_policy  (replace_policy),
    .write_policy    (write_policy),
    .resp_valid      (resp_valid),
    .resp_hit        (resp_hit),
    .resp_evict      (resp_evict),
    .resp_evict_tag  (resp_evict_tag),
    .resp_writeback  (resp_writeback),
    .read_count      (read_count),
    .write_count     (write_count),
    .hit_count       (hit_count),
    .miss_count      (miss_count),
    .writeback_count (writeback_count)
  );

  // Reference model: each set is a recency list, front = newest.
  typedef struct packed {
    logic        dirty;
    logic [35:0] tag;
  } line_t;

  line_t mset [64][$];
  int m_rd, m_wr, m_hit, m_miss, m_wbc;

  typedef struct {
    bit          rst;
    bit          wr;
    logic [47:0] addr;
    bit          repl;
    bit          wp;
    bit          hit;
    bit          ev;
    logic [35:0] ev_tag;
    bit          wb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit rst, input bit wr, input logic [47:0] addr, input bit repl,
                              input bit wp, input bit hit, input bit ev, input logic [35:0] ev_tag,
                              input bit wb);
    vec_t v;
    v.rst = rst; v.wr = wr; v.addr = addr; v.repl = repl; v.wp = wp;
    v.hit = hit; v.ev = ev; v.ev_tag = ev_tag; v.wb = wb;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int s = 0; s < 64; s++) mset[s].delete();
    m_rd = 0; m_wr = 0; m_hit = 0; m_miss = 0; m_wbc = 0;
  endtask

  task automatic model_req(input bit wr, input logic [47:0] a, input bit repl, input bit wp,
                           output bit hit, output bit ev, output bit wb, output logic [35:0] etag);
    int          s;
    int          pos;
    logic [35:0] t;
    line_t       q[$];
    line_t       ln;
    s = int'(a[11:6]);
    t = a[47:12];
    q = mset[s];
    pos = -1;
    hit = 1'b0; ev = 1'b0; wb = 1'b0; etag = '0;
    for (int i = 0; i < q.size(); i++) if (q[i].tag == t) pos = i;
    if (pos >= 0) begin
      hit = 1'b1;
      ln = q[pos];
      if (wr && !wp) ln.dirty = 1'b1;
      if (repl) begin
        q.delete(pos);
        q.push_front(ln);
      end else begin
        q[pos] = ln;
      end
    end else if (!wr || !wp) begin
      if (q.size() == 8) begin
        ln = q.pop_back();
        ev = 1'b1; wb = ln.dirty; etag = ln.tag;
      end
      ln.dirty = wr && !wp;
      ln.tag = t;
      q.push_front(ln);
    end
    mset[s] = q;
    if (wr) m_wr++; else m_rd++;
    if (hit) m_hit++; else m_miss++;
    if (wb || (wr && wp)) m_wbc++;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_read_count"},      64'(read_count),      64'(STATS ? m_rd : 0));
    check({tag, "_write_count"},     64'(write_count),     64'(STATS ? m_wr : 0));
    check({tag, "_hit_count"},       64'(hit_count),       64'(STATS ? m_hit : 0));
    check({tag, "_miss_count"},      64'(miss_count),      64'(STATS ? m_miss : 0));
    check({tag, "_writeback_count"}, 64'(writeback_count), 64'(STATS ? m_wbc : 0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_fields", {resp_hit, resp_evict, resp_writeback}, 0);
    check_counters("rst");
  endtask

  // Issues one request starting at a negedge in IDLE; returns at a negedge in IDLE.
  task automatic run_one(input bit wr, input logic [47:0] a, input bit repl, input bit wp,
                         output bit d_hit, output bit d_ev, output logic [35:0] d_tag, output bit d_wb);
    bit          m_h, m_e, m_w, got;
    logic [35:0] m_t;
    int          lat, n;
    req_write = wr; req_addr = a; replace_policy = repl; write_policy = wp; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0; lat = 0;
    for (int c = 1; c <= 16 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        lat = c;
      end
    end
    check("resp_latency", lat, 3);
    d_hit = resp_hit; d_ev = resp_evict; d_tag = resp_evict_tag; d_wb = resp_writeback;
    @(negedge clk);
    check("resp_pulse_width", resp_valid, 0);
    check("ready_return", req_ready, 1);
    model_req(wr, a, repl, wp, m_h, m_e, m_w, m_t);
    check("model_hit", d_hit, m_h);
    check("model_evict", d_ev, m_e);
    if (m_e) check("model_evict_tag", d_tag, m_t);
    check("model_writeback", d_wb, m_w);
    check_counters("model");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    bit          h, e, w, seen;
    logic [35:0] t;
    logic [35:0] tagv;
    logic [47:0] a;
    logic [47:0] b_addr;
    vec_t        v;

    b_addr = 48'h1234_5678_9AC0;

    // Cold read then hit on address 0.
    vecs.push_back(mk(1, 0, 48'h0, 0, 0, 0, 0, 36'd0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 1, 0, 36'd0, 0));
    // FIFO: nine conflicting reads in set 0, then re-read the first.
    for (int k = 0; k < 9; k++) vecs.push_back(mk(k == 0, 0, 48'(k * 4096), 0, 0, 0, k == 8, 36'd0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 0, 0, 0, 1, 36'd1, 0));
    // LRU: fill, touch A0, then A8 must displace A1.
    for (int k = 0; k < 8; k++) vecs.push_back(mk(k == 0, 0, 48'(k * 4096), 1, 0, 0, 0, 36'd0, 0));
    vecs.push_back(mk(0, 0, 48'h0, 1, 0, 1, 0, 36'd0, 0));
    vecs.push_back(mk(0, 0, 48'(8 * 4096), 1, 0, 0, 1, 36'd1, 0));
    // Write-back: dirty A0 written back when pushed out.
    vecs.push_back(mk(1, 1, 48'h0, 0, 0, 0, 0, 36'd0, 0));
    for (int k = 1; k < 8; k++) vecs.push_back(mk(0, 0, 48'(k * 4096), 0, 0, 0, 0, 36'd0, 0));
    vecs.push_back(mk(0, 0, 48'(8 * 4096), 0, 0, 0, 1, 36'd0, 1));
    // Write-through: write miss does not allocate; top-of-range address.
    vecs.push_back(mk(1, 1, b_addr, 0, 1, 0, 0, 36'd0, 0));
    vecs.push_back(mk(0, 0, b_addr, 0, 1, 0, 0, 36'd0, 0));
    vecs.push_back(mk(0, 0, 48'hFFFF_FFFF_FFFF, 0, 1, 0, 0, 36'd0, 0));
    vecs.push_back(mk(0, 0, 48'hFFFF_FFFF_FFC0, 0, 1, 1, 0, 36'd0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (v.rst) do_reset();
      run_one(v.wr, v.addr, v.repl, v.wp, h, e, t, w);
      check("tbl_hit", h, v.hit);
      check("tbl_evict", e, v.ev);
      if (v.ev) check("tbl_evict_tag", t, v.ev_tag);
      check("tbl_writeback", w, v.wb);
    end
    check("wt_read_count", 64'(read_count), STATS ? 64'd3 : 64'd0);
    check("wt_write_count", 64'(write_count), STATS ? 64'd1 : 64'd0);
    check("wt_hit_count", 64'(hit_count), STATS ? 64'd1 : 64'd0);
    check("wt_miss_count", 64'(miss_count), STATS ? 64'd3 : 64'd0);
    check("wt_writeback_count", 64'(writeback_count), STATS ? 64'd1 : 64'd0);

    // Reset during UPDATE aborts the request and clears the set.
    do_reset();
    run_one(1'b0, 48'h0000_0000_5040, 1'b0, 1'b0, h, e, t, w);
    check("abort_first_miss", h, 0);
    req_write = 1'b0; req_addr = 48'h0000_0000_5040; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    check("abort_no_resp", seen, 0);
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    check("abort_ready", req_ready, 1);
    check_counters("abort");
    run_one(1'b0, 48'h0000_0000_5040, 1'b0, 1'b0, h, e, t, w);
    check("abort_refetch_miss", h, 0);

    // Randomized: write-back phase, then write-through phase, replacement policy per request.
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        tagv = 36'($urandom_range(0, 11));
        if ($urandom_range(0, 3) == 0) tagv[35] = 1'b1;
        a = {tagv, 6'($urandom_range(0, 3)), 6'($urandom_range(0, 63))};
        run_one(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)), 1'(phase), h, e, t, w);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_tag_engine.md
# cache_tag_engine

Parametrised set-associative cache tag/state engine, successor to the single-configuration cache model. It accepts one address per valid/ready handshake and looks it up across all ways of its set. It applies FIFO or true-LRU replacement with write-back or write-through policy, reports hit/evict/writeback per request, and keeps saturating statistics. It sits between the trace/address source and the memory-side model.

## Interface
- ADDR_W, 48: request address width.
- BLOCKSIZE, 64: line size in bytes; power of two.
- CACHESIZE, 32768: capacity in bytes; power of two.
- ASSOC, 8: ways per set; power of two, ≥2.
- CNT_W, 32: statistics counter width.
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  1  request present.
- req_ready  out  1  engine can accept; high only in IDLE.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- replace_policy  in  1  0 = FIFO, 1 = LRU; sampled at accept.
- write_policy  in  1  0 = write-back/write-allocate, 1 = write-through/no-write-allocate; sampled at accept.
- resp_valid  out  1  one-cycle pulse, result fields valid.
- resp_hit  out  1  request hit.
- resp_evict  out  1  a valid line was replaced.
- resp_evict_tag  out  TAG_W  tag of replaced line.
- resp_writeback  out  1  dirty victim written back (write-back mode only).
- read_count, write_count, hit_count, miss_count, writeback_count  out  CNT_W each  statistics.

## Operation
- Derived: OFFSET_W = log2(BLOCKSIZE), NUMSETS = CACHESIZE/(BLOCKSIZE·ASSOC), INDEX_W = log2(NUMSETS), TAG_W = ADDR_W−OFFSET_W−INDEX_W. index = addr[OFFSET_W +: INDEX_W], tag = upper TAG_W bits.
- Per way: valid, dirty, tag, age (log2 ASSOC bits). Age 0 = newest. Valid ways in a set hold distinct ages.
- FSM: IDLE → (req_valid) → LOOKUP → UPDATE → RESP → IDLE.
  - IDLE: req_ready=1; on handshake, latch addr, write, and both policies.
  - LOOKUP: parallel compare of valid ways; hit way found; victim = lowest-index invalid way, else the way whose age = ASSOC−1.
  - UPDATE, hit: LRU sets hit way age 0 and increments valid ways younger than its old age; FIFO leaves ages unchanged. A write hit in write-back mode sets dirty.
  - UPDATE, miss with allocate (any read; write in write-back): fill victim with valid=1 and age 0, and increment all other valid ways' ages. dirty = req_write && write-back. resp_evict = victim was valid. resp_writeback = victim valid && dirty.
  - UPDATE, write miss in write-through: no allocation and no state change.
  - RESP: resp_valid=1 for exactly one cycle.
- Counters increment at RESP and saturate at all-ones:
  - read_count or write_count, by request type.
  - hit_count or miss_count, by result.
  - writeback_count on a dirty eviction, and on every write in write-through mode.
- Address 0 is a legal request; there is no sentinel value.

## Timing
- Handshake at edge N; resp_valid high during cycle N+3; req_ready returns high in cycle N+4. Throughput is one request per 4 cycles.
- req_valid while req_ready=0 is ignored; the source holds it.
- Reset values: req_ready=1 (after release), resp_* = 0, all counters 0, all valid/dirty/age bits 0.
- Reset asserted mid-request aborts the request with no response; the set is left fully cleared.
- A policy change between requests takes effect at the next accept. Existing ages are reused as-is.

## Configuration
- CACHE_STATS_EN defined: the five counters and their saturation logic are present.
- CACHE_STATS_EN undefined: the counters are tied to 0, no counter flops exist, and all other behaviour is identical.

## Structure
- Package cache_pkg holds:
  - state enum (IDLE, LOOKUP, UPDATE, RESP);
  - policy constants (FIFO, LRU, WB, WT);
  - a function computing log2 widths.
- Tag/valid/dirty/age storage lives in the top.
- One sub-module, cache_way_select: combinational hit detection, hit way, victim way, and priority encoders, parametrised by ASSOC and TAG_W.

## Test plan
- Reset, then read 0x0: resp_hit=0, resp_evict=0, miss_count=1, read_count=1. Repeat read 0x0: resp_hit=1, hit_count=1.
- FIFO, ASSOC=8: read 9 addresses mapping to set 0 (stride 4096 B), then re-read the first: miss, resp_evict=1, resp_evict_tag = tag of the 2nd address.
- LRU: fill set 0 with A0–A7, re-read A0, then read A8: the victim is A1, not A0.
- Write-back: write A0, then read 8 new conflicting lines: resp_writeback=1 when A0 is evicted, writeback_count=1.
- Write-through: write miss to B, then read B: first response is a miss with no allocation, second is a miss; writeback_count=1, write_count=1.
- Assert reset during UPDATE: no resp_valid, counters 0, next read of the prior address misses.
